frame_point_buffer: RTL and testbench
=====================================

// Module: frame_point_buffer
// PURPOSE
// Upstream stage of the vector display pipeline. Parses a byte stream from the UART receiver into point frames.
// Frames are stored in a double-buffered point RAM: the back bank is written while the line-draw sequencer reads the front bank by index.
// Banks swap only at the draw loop's end-of-frame strobe, so the displayed image never tears.
// PARAMETERS
// AW       11         index/count width; bank depth 2**AW, max points per frame (2**AW)-1
// TIMEOUT  100000     clk cycles of inter-byte silence inside a frame before abort
// PORTS
// clk            in   1      system clock
// reset          in   1      sync reset, active-high
// rx_valid       in   1      1-cycle strobe, rx_data holds a received byte
// rx_data        in   8      received byte
// index          in   AW     front-bank read address from draw loop
// done_drawing   in   1      1-cycle strobe: draw loop finished the front frame
// point          out  25     {draw_bit, x[11:0], y[11:0]} at front[index], registered
// num_pts        out  AW     point count of the front frame
// drawing        out  1      high once the first complete frame has been swapped in
// frame_pending  out  1      back bank holds a complete, not-yet-displayed frame
// frame_err      out  1      1-cycle strobe on protocol error or timeout
// BEHAVIOUR
// Reset values: point=0, num_pts=0, drawing=0, frame_pending=0, frame_err=0, front bank=0, parser=SYNC0.
// Frame format: A5 5A CNT_HI CNT_LO, then CNT points of 4 bytes each, big-endian.
//   Point bytes b0..b3: point = {b0[0], b1, b2, b3}; b0[7:1] are ignored.
// Parser FSM advances only on rx_valid:
//   SYNC0 : A5 -> SYNC1; any other byte -> SYNC0.
//   SYNC1 : 5A -> CNT_HI; A5 -> SYNC1; else -> SYNC0.
//   CNT_HI: latch cnt[15:8] -> CNT_LO.
//   CNT_LO: form cnt.
//     cnt==0 -> empty frame complete: back_count=0, frame_pending=1 -> SYNC0.
//     cnt > (2**AW)-1 -> frame_err pulse -> SYNC0.
//     otherwise clear frame_pending, wr_ptr=0, byte_idx=0 -> DATA.
//   DATA  : shift byte into 32-bit assembler. On byte_idx==3, write the 25-bit point to back[wr_ptr] and increment wr_ptr.
//     When wr_ptr+1 == cnt: back_count=cnt, frame_pending=1 -> SYNC0.
// Timeout: a counter clears on every rx_valid and counts while state != SYNC0.
//   Reaching TIMEOUT gives a frame_err pulse and -> SYNC0. frame_pending stays 0, so a partial frame is never shown.
// A new frame entering DATA clears frame_pending: the back bank is being overwritten and is no longer swappable. Newest frame wins.
// Swap on done_drawing && frame_pending: front<=~front, num_pts<=back_count, frame_pending<=0, drawing<=1.
// done_drawing && !frame_pending: no change; the front frame is redrawn.
// Simultaneous done_drawing and the completing byte: the swap decision uses the pre-update frame_pending (0), so no swap that cycle.
//   frame_pending rises and the frame swaps at the next done_drawing.
// Read: point is valid 1 clk after index. Reads and writes always target opposite banks, so there is no collision.
// index >= num_pts returns stale RAM contents; the draw loop must not use them.
// reset mid-frame: parser -> SYNC0, partial data discarded, drawing=0, num_pts=0.
// cnt arithmetic is 16-bit unsigned. wr_ptr is AW bits and cannot wrap, since cnt <= (2**AW)-1.
// TESTING
// 1. Send A5 5A 00 02, then 01 00 10 20, then 00 ABC DEF packed as 00 AB CD EF, then done_drawing.
//    -> drawing=1, num_pts=2; index 0 -> point=1_001_020 and index 1 -> 0_ABC_DEF, each 1 clk later.
// 2. Complete frame B while frame A displays; pulse done_drawing twice.
//    -> first pulse swaps to B; second leaves num_pts and contents of B unchanged.
// 3. Send A5 5A 08 00 (cnt=2048 with AW=11) -> frame_err pulse, parser in SYNC0, frame_pending=0.
// 4. Send the header plus 3 bytes, then TIMEOUT idle cycles.
//    -> frame_err pulse; a following valid 1-point frame parses correctly.
// 5. Send A5 A5 5A 00 00 -> empty frame pending; done_drawing -> num_pts=0, drawing=1.
// 6. Final byte and done_drawing on the same cycle -> no swap; swap occurs on the next done_drawing.

Source files
------------

// File: rtl/frame_point_buffer_if.sv
// Byte-stream in, draw-loop read port and frame status out, for frame_point_buffer.
interface frame_point_buffer_if #(parameter int AW = 11);
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic [AW-1:0] index;
   logic          done_drawing;
   logic [24:0]   point;
   logic [AW-1:0] num_pts;
   logic          drawing;
   logic          frame_pending;
   logic          frame_err;

   modport master (
      output rx_valid, rx_data, index, done_drawing,
      input  point, num_pts, drawing, frame_pending, frame_err
   );

   modport slave (
      input  rx_valid, rx_data, index, done_drawing,
      output point, num_pts, drawing, frame_pending, frame_err
   );
endinterface

// File: rtl/frame_point_buffer.sv
// Parses A5 5A CNT point frames from a byte stream into a double-buffered point RAM;
// banks swap only on the draw loop's end-of-frame strobe.
module frame_point_buffer #(
   parameter int AW      = 11,
   parameter int TIMEOUT = 100000
) (
   input  logic                clk,
   input  logic                reset,
   frame_point_buffer_if.slave bus
);
   localparam int          TW      = $clog2(TIMEOUT + 1);
   localparam logic [15:0] MAX_CNT = 16'((1 << AW) - 1);

   typedef enum logic [2:0] {SYNC0, SYNC1, CNT_HI, CNT_LO, DATA} state_t;

   state_t        state, state_n;
   logic [TW-1:0] tmo;
   logic [7:0]    cnt_hi;
   logic [15:0]   cnt, cnt_rx;
   logic [AW-1:0] wr_ptr, back_count, num_pts;
   logic [1:0]    byte_idx;
   logic [16:0]   asm_r;
   logic          front, pending, drawing, err;
   logic [24:0]   point, wr_data;
   logic          start, fin_empty, fin_data, wr_en, err_c, timed_out, swap;

   logic [24:0]   mem [2**(AW+1)];

   assign cnt_rx  = {cnt_hi, bus.rx_data};
   // b0[7:1] are don't-care; asm_r holds {b0[0], b1, b2} when b3 arrives
   assign wr_data = {asm_r[16], asm_r[15:0], bus.rx_data};
   assign swap    = bus.done_drawing && pending;

   always_ff @(posedge clk) begin
      if (reset) state <= SYNC0;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      start     = 1'b0;
      fin_empty = 1'b0;
      fin_data  = 1'b0;
      wr_en     = 1'b0;
      err_c     = 1'b0;
      timed_out = !bus.rx_valid && (state != SYNC0) && (tmo == TW'(TIMEOUT - 1));
      if (timed_out) begin
         err_c   = 1'b1;
         state_n = SYNC0;
      end else if (bus.rx_valid) begin
         case (state)
            SYNC0:  if (bus.rx_data == 8'hA5) state_n = SYNC1;
            SYNC1:  begin
               if (bus.rx_data == 8'h5A)      state_n = CNT_HI;
               else if (bus.rx_data == 8'hA5) state_n = SYNC1;
               else                           state_n = SYNC0;
            end
            CNT_HI: state_n = CNT_LO;
            CNT_LO: begin
               if (cnt_rx == 16'd0) begin
                  fin_empty = 1'b1;
                  state_n   = SYNC0;
               end else if (cnt_rx > MAX_CNT) begin
                  err_c   = 1'b1;
                  state_n = SYNC0;
               end else begin
                  start   = 1'b1;
                  state_n = DATA;
               end
            end
            DATA: begin
               if (byte_idx == 2'd3) begin
                  wr_en = 1'b1;
                  if (16'(wr_ptr) + 16'd1 == cnt) begin
                     fin_data = 1'b1;
                     state_n  = SYNC0;
                  end
               end
            end
            default: state_n = SYNC0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo        <= '0;
         cnt_hi     <= '0;
         cnt        <= '0;
         wr_ptr     <= '0;
         byte_idx   <= '0;
         asm_r      <= '0;
         back_count <= '0;
         pending    <= 1'b0;
         front      <= 1'b0;
         num_pts    <= '0;
         drawing    <= 1'b0;
         err        <= 1'b0;
         point      <= '0;
      end else begin
         err   <= err_c;
         point <= mem[{front, bus.index}];

         if (bus.rx_valid || timed_out || state == SYNC0) tmo <= '0;
         else                                             tmo <= tmo + 1'b1;

         if (bus.rx_valid && state == CNT_HI) cnt_hi <= bus.rx_data;

         if (start) begin
            cnt      <= cnt_rx;
            wr_ptr   <= '0;
            byte_idx <= '0;
         end else if (bus.rx_valid && state == DATA) begin
            asm_r    <= {asm_r[8:0], bus.rx_data};
            byte_idx <= byte_idx + 2'd1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         end

         if (fin_empty) back_count <= '0;
         if (fin_data)  back_count <= AW'(cnt);

         // The swap decision reads the pre-update pending, so a frame completing
         // in the same cycle as done_drawing waits for the next strobe.
         if (fin_empty || fin_data) pending <= 1'b1;
         else if (start || swap)    pending <= 1'b0;

         if (swap) begin
            front   <= ~front;
            num_pts <= back_count;
            drawing <= 1'b1;
         end
      end
   end

   // pending is low throughout DATA, so front never flips while the back bank is written
   always_ff @(posedge clk) begin
      if (wr_en) mem[{~front, wr_ptr}] <= wr_data;
   end

   assign bus.point         = point;
   assign bus.num_pts       = num_pts;
   assign bus.drawing       = drawing;
   assign bus.frame_pending = pending;
   assign bus.frame_err     = err;
endmodule

// File: tb/tb_frame_point_buffer.sv
// Randomized scoreboard bench for frame_point_buffer with a frame-level reference model.
module tb_frame_point_buffer;
   localparam int AW      = 11;
   localparam int TIMEOUT = 50;
   localparam int MAXP    = (1 << AW) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   frame_point_buffer_if #(.AW(AW)) bus ();
   frame_point_buffer #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));

   typedef struct {
      logic [24:0] pt;
      string       name;
   } pt_exp_t;

   typedef struct {
      bit          chk_pt;
      logic [24:0] pt;
      int          num;
      bit          drawing;
      bit          pending;
      string       name;
   } st_exp_t;

   pt_exp_t pt_q[$];
   st_exp_t st_q[$];
   string   err_q[$];
   int      n_cmp = 0;
   int      n_bad = 0;
   bit      rd_req = 1'b0, rd_pend = 1'b0, st_req = 1'b0;

   // Reference model: frames as whole point lists
   logic [24:0] m_front[$], m_back[$];
   int          m_num = 0, m_back_num = 0;
   bit          m_drawing = 1'b0, m_pending = 1'b0;

   always @(posedge clk) rd_pend <= rd_req;

   always @(negedge clk) begin
      pt_exp_t pe;
      st_exp_t se;
      if (rd_pend) begin
         n_cmp++;
         if (pt_q.size() == 0) begin
            n_bad++;
            $display("FAIL read: point=%h with no expectation queued", bus.point);
         end else begin
            pe = pt_q.pop_front();
            if (bus.point !== pe.pt) begin
               n_bad++;
               $display("FAIL %s: point=%h required %h", pe.name, bus.point, pe.pt);
            end
         end
      end
      if (st_req) begin
         n_cmp++;
         if (st_q.size() == 0) begin
            n_bad++;
            $display("FAIL status: no expectation queued");
         end else begin
            se = st_q.pop_front();
            if (bus.num_pts !== AW'(se.num) || bus.drawing !== se.drawing ||
                bus.frame_pending !== se.pending || (se.chk_pt && bus.point !== se.pt)) begin
               n_bad++;
               $display("FAIL %s: num=%0d drawing=%b pending=%b point=%h required num=%0d drawing=%b pending=%b point=%h",
                        se.name, bus.num_pts, bus.drawing, bus.frame_pending, bus.point,
                        se.num, se.drawing, se.pending, se.pt);
            end
         end
      end
      if (!reset && bus.frame_err !== 1'b0) begin
         n_cmp++;
         if (err_q.size() == 0) begin
            n_bad++;
            $display("FAIL frame_err: got %b required 0 (unexpected pulse)", bus.frame_err);
         end else void'(err_q.pop_front());
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic void model_swap();
      if (m_pending) begin
         m_front   = m_back;
         m_num     = m_back_num;
         m_pending = 1'b0;
         m_drawing = 1'b1;
      end
   endfunction

   function automatic void model_reset();
      m_num = 0; m_drawing = 1'b0; m_pending = 1'b0; m_back_num = 0;
   endfunction

   function automatic bit rdd(input bit rnd);
      return rnd && ($urandom_range(0, 5) == 0);
   endfunction

   task automatic gap(input bit rnd);
      if (rnd) repeat ($urandom_range(0, 2)) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit dd);
      bus.rx_valid = 1'b1; bus.rx_data = b; bus.done_drawing = dd;
      tick();
      bus.rx_valid = 1'b0; bus.done_drawing = 1'b0;
      if (dd) model_swap();
   endtask

   task automatic do_done();
      bus.done_drawing = 1'b1;
      tick();
      bus.done_drawing = 1'b0;
      model_swap();
   endtask

   task automatic chk_status(input string name, input bit chk_pt = 1'b0, input logic [24:0] pt = '0);
      st_exp_t se;
      se.chk_pt = chk_pt; se.pt = pt; se.num = m_num;
      se.drawing = m_drawing; se.pending = m_pending; se.name = name;
      st_q.push_back(se);
      st_req = 1'b1;
      tick();
      st_req = 1'b0;
   endtask

   task automatic rd_check(input int i, input string name);
      pt_exp_t pe;
      pe.pt = m_front[i]; pe.name = name;
      pt_q.push_back(pe);
      bus.index = AW'(i); rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   task automatic rd_all(input string name);
      for (int i = 0; i < m_num; i++) rd_check(i, name);
   endtask

   task automatic chk_err_drained(input string name);
      n_cmp++;
      if (err_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d frame_err pulses missing, required 0", name, err_q.size());
      end
      err_q.delete();
   endtask

   task automatic send_frame(input int n, input logic [24:0] pts[$], input bit rnd, input bit last_dd);
      logic [15:0] c;
      logic [24:0] p;
      c = 16'(n);
      send_byte(8'hA5, rdd(rnd)); gap(rnd);
      send_byte(8'h5A, rdd(rnd)); gap(rnd);
      send_byte(c[15:8], rdd(rnd)); gap(rnd);
      if (n > MAXP) err_q.push_back("cnt_over");
      send_byte(c[7:0], (n == 0) ? last_dd : rdd(rnd));
      if (n == 0) begin
         m_pending = 1'b1; m_back_num = 0; m_back.delete();
         return;
      end
      if (n > MAXP) return;
      m_pending = 1'b0;
      for (int i = 0; i < n; i++) begin
         p = pts[i];
         gap(rnd); send_byte({7'($urandom), p[24]}, rdd(rnd));
         gap(rnd); send_byte(p[23:16], rdd(rnd));
         gap(rnd); send_byte(p[15:8], rdd(rnd));
         gap(rnd); send_byte(p[7:0], (i == n - 1) ? last_dd : rdd(rnd));
      end
      m_pending = 1'b1; m_back = pts; m_back_num = n;
   endtask

   function automatic void rand_pts(input int n, output logic [24:0] q[$]);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(25'($urandom));
   endfunction

   initial begin
      logic [24:0] pts[$];
      logic [7:0]  g;
      bus.rx_valid = 1'b0; bus.rx_data = '0; bus.index = '0; bus.done_drawing = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      chk_status("reset_state", 1'b1, 25'h0);
      reset = 1'b0;

      // Two-point frame from the worked example
      pts = {25'h1001020, 25'h0ABCDEF};
      send_frame(2, pts, 1'b0, 1'b0);
      chk_status("t1_pending");
      do_done();
      chk_status("t1_swapped");
      rd_check(0, "t1_pt0");
      rd_check(1, "t1_pt1");

      // Frame B built while A displays; second done_drawing redraws B
      rand_pts(3, pts);
      send_frame(3, pts, 1'b1, 1'b0);
      rd_all("t2_front_a");
      chk_status("t2_b_pending");
      do_done();
      chk_status("t2_first_done");
      rd_all("t2_b");
      do_done();
      chk_status("t2_second_done");
      rd_all("t2_b_again");

      // Count overflow and max-size frame
      send_frame(2048, pts, 1'b0, 1'b0);
      chk_status("t3_cnt2048");
      chk_err_drained("t3_err2048");
      send_frame(16'hFFFF, pts, 1'b0, 1'b0);
      chk_status("t3_cntffff");
      chk_err_drained("t3_errffff");
      rand_pts(MAXP, pts);
      send_frame(MAXP, pts, 1'b0, 1'b0);
      do_done();
      chk_status("t3_max_frame");
      rd_check(0, "t3_max_first");
      rd_check(MAXP - 1, "t3_max_last");

      // Timeout after header plus 3 bytes, then a good 1-point frame
      send_byte(8'hA5, 1'b0); send_byte(8'h5A, 1'b0);
      send_byte(8'h00, 1'b0); send_byte(8'h01, 1'b0);
      m_pending = 1'b0;
      send_byte(8'h01, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
      err_q.push_back("timeout");
      repeat (TIMEOUT + 3) tick();
      chk_err_drained("t4_timeout");
      chk_status("t4_after_abort");
      pts = {25'h1ABC123};
      send_frame(1, pts, 1'b0, 1'b0);
      do_done();
      chk_status("t4_recover");
      rd_check(0, "t4_pt0");

      // Garbage, false sync, then A5 A5 5A 00 00 empty frame
      for (int i = 0; i < 6; i++) begin
         g = 8'($urandom);
         if (g == 8'hA5) g = 8'h00;
         send_byte(g, 1'b0);
      end
      send_byte(8'hA5, 1'b0); send_byte(8'h33, 1'b0);
      send_byte(8'hA5, 1'b0); send_byte(8'hA5, 1'b0); send_byte(8'h5A, 1'b0);
      send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
      m_pending = 1'b1; m_back_num = 0; m_back.delete();
      chk_status("t5_empty_pending");
      do_done();
      chk_status("t5_empty_swapped");

      // Completing byte coincides with done_drawing
      rand_pts(2, pts);
      send_frame(2, pts, 1'b0, 1'b1);
      chk_status("t6_no_swap");
      do_done();
      chk_status("t6_late_swap");
      rd_all("t6_pts");

      // Reset in the middle of a frame
      send_byte(8'hA5, 1'b0); send_byte(8'h5A, 1'b0);
      send_byte(8'h00, 1'b0); send_byte(8'h03, 1'b0);
      send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0);
      reset = 1'b1; tick(); reset = 1'b0;
      model_reset();
      chk_status("t7_reset_mid");
      rand_pts(2, pts);
      send_frame(2, pts, 1'b0, 1'b0);
      do_done();
      chk_status("t7_recover");
      rd_all("t7_pts");

      // Randomized frames with stray done_drawing strobes
      for (int k = 0; k < 10; k++) begin
         int n;
         n = $urandom_range(0, 6);
         rand_pts(n, pts);
         send_frame(n, pts, 1'b1, rdd(1'b1));
         if ($urandom_range(0, 1) == 1) do_done();
         chk_status("rnd_status");
         rd_all("rnd_pts");
      end

      repeat (5) tick();
      chk_err_drained("final_err");
      n_cmp++;
      if (pt_q.size() != 0 || st_q.size() != 0) begin
         n_bad++;
         $display("FAIL final_queues: %0d point and %0d status expectations left, required 0",
                  pt_q.size(), st_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
